// File: rtl/pulp_io_pkg.sv
// Shared types for the pulp-io UART receiver: FSM states, data-width encoding, limits.
package pulp_io_pkg;

    localparam int UART_MAX_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    typedef enum logic [1:0] {
        BITS_5 = 2'd0,
        BITS_6 = 2'd1,
        BITS_7 = 2'd2,
        BITS_8 = 2'd3
    } uart_bits_e;

    // Index of the last data bit for a cfg_bits encoding (5..8 bits -> 4..7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        return {1'b0, bits} + 3'd4;
    endfunction

endpackage

// File: rtl/pulp_io_sync.sv
// Multi-flop bit synchronizer for pad inputs; flops reset to RST_VAL.
module pulp_io_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ff <= {STAGES{RST_VAL}};
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pulp_io_uart_rx.sv
// UART receiver: synchronized rx line -> start/data/[parity]/stop deframer -> valid/ready byte.
// Parity checking is compiled in only when PULP_IO_UART_RX_PARITY_EN is defined.
module pulp_io_uart_rx
    import pulp_io_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             rx_i,
    input  logic             cfg_en_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_bits_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_parity_odd_i,
    input  logic             cfg_stop2_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             err_frame_o,
    output logic             err_parity_o,
    output logic             err_overrun_o
);

    localparam int IDX_W = $clog2(UART_MAX_BITS);

    uart_rx_state_e           state, state_n;
    logic [DIV_W-1:0]         baud_cnt, baud_n, half;
    logic [IDX_W-1:0]         bit_idx, bit_n;
    logic [UART_MAX_BITS-1:0] shreg, shreg_n;
    logic                     stop_idx, stop_n, frm_flag, frm_n;
    logic                     rx_s, rx_q, tick, done, par_bad, good;

    pulp_io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk  (clk_i),
        .rstn (rstn_i),
        .d    (rx_i),
        .q    (rx_s)
    );

`ifdef PULP_IO_UART_RX_PARITY_EN
    logic par_flag, par_n;
    assign par_bad = par_flag;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = cfg_parity_en_i ^ cfg_parity_odd_i;
    assign par_bad = 1'b0;
`endif

    assign half   = cfg_div_i >> 1;
    assign tick   = (baud_cnt == cfg_div_i);
    assign busy_o = (state != IDLE);
    assign good   = done && !frm_n && !par_bad;

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        stop_n  = stop_idx;
        frm_n   = frm_flag;
        done    = 1'b0;
`ifdef PULP_IO_UART_RX_PARITY_EN
        par_n   = par_flag;
`endif
        if (state != IDLE && !cfg_en_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                // Start only on a fresh falling edge, so a held-low line (break) cannot re-trigger.
                IDLE: if (cfg_en_i && rx_q && !rx_s) begin
                    state_n = START;
                    baud_n  = '0;
                end
                START: if (baud_cnt == half) begin
                    baud_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        bit_n   = '0;
                        shreg_n = '0;
                        stop_n  = 1'b0;
                        frm_n   = 1'b0;
`ifdef PULP_IO_UART_RX_PARITY_EN
                        par_n   = 1'b0;
`endif
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
                DATA: if (tick) begin
                    baud_n           = '0;
                    shreg_n[bit_idx] = rx_s;
                    if (bit_idx == last_bit_idx(cfg_bits_i)) begin
`ifdef PULP_IO_UART_RX_PARITY_EN
                        state_n = cfg_parity_en_i ? PARITY : STOP;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
`ifdef PULP_IO_UART_RX_PARITY_EN
                // Unused upper shreg bits are zero, so a full-width XOR covers any width.
                PARITY: if (tick) begin
                    baud_n  = '0;
                    par_n   = rx_s != ((^shreg) ^ cfg_parity_odd_i);
                    state_n = STOP;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
`endif
                STOP: if (tick) begin
                    baud_n = '0;
                    frm_n  = frm_flag | ~rx_s;
                    if (stop_idx == cfg_stop2_i) begin
                        state_n = IDLE;
                        done    = 1'b1;
                    end else begin
                        stop_n = 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            stop_idx <= 1'b0;
            frm_flag <= 1'b0;
            rx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= shreg_n;
            stop_idx <= stop_n;
            frm_flag <= frm_n;
            rx_q     <= rx_s;
        end
    end

    // Frame error outranks parity error; a good byte either loads or is dropped as overrun.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_o        <= '0;
            valid_o       <= 1'b0;
            err_frame_o   <= 1'b0;
            err_overrun_o <= 1'b0;
        end else begin
            err_frame_o   <= done && frm_n;
            err_overrun_o <= good && valid_o && !ready_i;
            if (good && (!valid_o || ready_i)) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef PULP_IO_UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            par_flag     <= 1'b0;
            err_parity_o <= 1'b0;
        end else begin
            par_flag     <= par_n;
            err_parity_o <= done && !frm_n && par_flag;
        end
    end
`else
    assign err_parity_o = 1'b0;
`endif

endmodule

// File: tb/tb_pulp_io_uart_rx.sv
// Directed bench for pulp_io_uart_rx: frame-level outcome model plus per-cycle output compare.
module tb_pulp_io_uart_rx;

    typedef enum int {EV_GOOD, EV_FRAME, EV_PARITY, EV_ABORT} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        rx_i = 1'b1;
    logic        cfg_en_i = 1'b1;
    logic [15:0] cfg_div_i = 16'd9;
    logic [1:0]  cfg_bits_i = 2'd3;
    logic        cfg_parity_en_i = 1'b0;
    logic        cfg_parity_odd_i = 1'b0;
    logic        cfg_stop2_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [7:0]  data_o;
    logic        valid_o, busy_o, err_frame_o, err_parity_o, err_overrun_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_k = 0;
    int rise_cyc = 0;
    int n_frm = 0, n_par = 0, n_ovr = 0;
    ev_t evq[$];

    pulp_io_uart_rx #(.DIV_W(16), .SYNC_STAGES(2)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .rx_i             (rx_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_div_i        (cfg_div_i),
        .cfg_bits_i       (cfg_bits_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_odd_i (cfg_parity_odd_i),
        .cfg_stop2_i      (cfg_stop2_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .busy_o           (busy_o),
        .err_frame_o      (err_frame_o),
        .err_parity_o     (err_parity_o),
        .err_overrun_o    (err_overrun_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Outcome of one frame from the line contents alone.
    function automatic ev_kind_e frame_kind(input logic [7:0] d, input bit par_used, input bit pbit,
                                            input bit odd, input bit s0, input bit s1_used, input bit s1);
        if (!s0 || (s1_used && !s1)) return EV_FRAME;
        if (par_used && (pbit != ((^d) ^ odd))) return EV_PARITY;
        return EV_GOOD;
    endfunction

    // Per-cycle compare: a frame ends when busy_o falls; its queued outcome decides the outputs.
    initial begin
        logic mv, pbusy, pvalid, pready, nv, ef, ep, eo;
        logic [7:0] md, nd;
        ev_t e;
        mv = 0; md = 0; pbusy = 0; pvalid = 0; pready = 0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                check("reset_outputs", {valid_o, busy_o, err_frame_o, err_parity_o, err_overrun_o, data_o}, 0);
                mv = 0; md = 0; pbusy = 0; pvalid = 0; pready = ready_i;
            end else begin
                nv = mv; nd = md; ef = 0; ep = 0; eo = 0;
                if (mv && pready) nv = 0;
                if (pbusy && !busy_o) begin
                    if (evq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame_end: got busy fall expected none (cyc %0d)", cyc);
                    end else begin
                        e = evq.pop_front();
                        case (e.kind)
                            EV_GOOD:   if (mv && !pready) eo = 1; else begin nv = 1; nd = e.data; end
                            EV_FRAME:  ef = 1;
                            EV_PARITY: ep = 1;
                            default:   ;
                        endcase
                    end
                end
                mv = nv; md = nd;
                check("valid", valid_o, mv);
                if (mv) check("data", data_o, md);
                check("err_frame", err_frame_o, ef);
                check("err_parity", err_parity_o, ep);
                check("err_overrun", err_overrun_o, eo);
                if (valid_o && !pvalid) rise_cyc = cyc;
                n_frm += int'(err_frame_o);
                n_par += int'(err_parity_o);
                n_ovr += int'(err_overrun_o);
                pbusy = busy_o; pvalid = valid_o; pready = ready_i;
            end
        end
    end

    task automatic drive_bit(input bit b, input int div);
        @(posedge clk_i);
        #1 rx_i = b;
        repeat (div) @(posedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input int div, input bit par_used,
                              input bit pbit, input bit s0, input bit s1_used, input bit s1);
        drive_bit(1'b0, div);
        frame_k = cyc - div;
        for (int i = 0; i < nb; i++) drive_bit(d[i], div);
        if (par_used) drive_bit(pbit, div);
        drive_bit(s0, div);
        if (s1_used) drive_bit(s1, div);
    endtask

    task automatic line_idle(input int n);
        @(posedge clk_i);
        #1 rx_i = 1'b1;
        repeat (n) @(posedge clk_i);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((evq.size() != 0 || busy_o) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        #1;
        check({name, "_done"}, {31'd0, evq.size() == 0 && !busy_o}, 1);
    endtask

    // Queue the expected outcome, then put the frame on the line.
    task automatic xfer(input logic [7:0] d, input bit flip, input bit s0, input bit s1);
        int nb;
        bit pu, pb;
        logic [7:0] dm;
        ev_t e;
        nb = int'(cfg_bits_i) + 5;
        dm = d & 8'((1 << nb) - 1);
`ifdef PULP_IO_UART_RX_PARITY_EN
        pu = cfg_parity_en_i;
`else
        pu = 1'b0;
`endif
        pb = (^dm) ^ cfg_parity_odd_i ^ flip;
        e.kind = frame_kind(dm, pu, pb, cfg_parity_odd_i, s0, cfg_stop2_i, s1);
        e.data = dm;
        evq.push_back(e);
        send_frame(dm, nb, int'(cfg_div_i), pu, pb, s0, cfg_stop2_i, s1);
    endtask

    task automatic push_abort();
        ev_t e;
        e.kind = EV_ABORT;
        e.data = 8'h00;
        evq.push_back(e);
    endtask

    initial begin
        int f0, p0, o0;
        repeat (4) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        repeat (5) @(posedge clk_i);

        // 8N1 0xA5 at div=9: valid rises 98 cycles after the start edge is driven.
        xfer(8'hA5, 0, 1, 1);
        line_idle(10);
        wait_done("a5");
        check("a5_latency", rise_cyc - frame_k, 98);
        check("a5_data", data_o, 8'hA5);
        check("a5_no_err", n_frm + n_par + n_ovr, 0);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("a5_consumed", valid_o, 0);

`ifdef PULP_IO_UART_RX_PARITY_EN
        cfg_bits_i = 2'd2; cfg_parity_en_i = 1'b1; cfg_parity_odd_i = 1'b0; ready_i = 1'b0;
        xfer(8'h35, 0, 1, 1);
        line_idle(10);
        wait_done("par_ok");
        check("par_ok_data", data_o, 8'h35);
        #1 ready_i = 1'b1;
        p0 = n_par;
        xfer(8'h35, 1, 1, 1);
        line_idle(10);
        wait_done("par_bad");
        check("par_bad_pulses", n_par - p0, 1);
        f0 = n_frm;
        xfer(8'h35, 1, 0, 1);
        line_idle(10);
        wait_done("par_and_frame");
        check("par_and_frame", {n_frm - f0, n_par - p0}, {32'd1, 32'd1});
        cfg_parity_odd_i = 1'b1;
        xfer(8'h6B, 0, 1, 1);
        line_idle(10);
        wait_done("par_odd");
`else
        cfg_parity_en_i = 1'b1; cfg_parity_odd_i = 1'b1;
        xfer(8'h5A, 0, 1, 1);
        line_idle(10);
        wait_done("par_ignored");
        check("par_ignored_no_pulse", n_par, 0);
`endif
        cfg_bits_i = 2'd3; cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0;

        // Stop bit low, then line held low (break): one frame error, no restart until high.
        f0 = n_frm;
        xfer(8'h3C, 0, 0, 1);
        repeat (40) @(posedge clk_i);
        line_idle(20);
        wait_done("break");
        check("break_frame_pulses", n_frm - f0, 1);
        xfer(8'h11, 0, 1, 1);
        line_idle(10);
        wait_done("after_break");

        // Overrun: hold the first byte, the second is dropped.
        #1 ready_i = 1'b0;
        o0 = n_ovr;
        xfer(8'h01, 0, 1, 1);
        line_idle(5);
        xfer(8'h02, 0, 1, 1);
        line_idle(10);
        wait_done("overrun");
        check("overrun_kept", {valid_o, data_o}, {1'b1, 8'h01});
        check("overrun_pulses", n_ovr - o0, 1);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("overrun_cleared", valid_o, 0);

        // 3-cycle glitch at div=15 is rejected in START.
        cfg_div_i = 16'd15;
        f0 = n_frm + n_par + n_ovr;
        push_abort();
        @(posedge clk_i);
        #1 rx_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rx_i = 1'b1;
        repeat (30) @(posedge clk_i);
        wait_done("glitch");
        check("glitch_quiet", {valid_o, 31'(n_frm + n_par + n_ovr - f0)}, 0);

        // Two stop bits, then a second stop bit driven low; then 5-bit data at div=3.
        cfg_stop2_i = 1'b1;
        xfer(8'h96, 0, 1, 1);
        line_idle(20);
        wait_done("stop2_ok");
        xfer(8'hC3, 0, 1, 0);
        line_idle(20);
        wait_done("stop2_bad");
        cfg_stop2_i = 1'b0; cfg_div_i = 16'd3; cfg_bits_i = 2'd0;
        xfer(8'h15, 0, 1, 1);
        line_idle(8);
        wait_done("bits5");
        xfer(8'h0A, 0, 1, 1);
        line_idle(8);
        wait_done("bits5b");

        // Disable mid-frame: partial frame dropped silently, held byte untouched.
        cfg_div_i = 16'd9; cfg_bits_i = 2'd3;
        #1 ready_i = 1'b0;
        xfer(8'h42, 0, 1, 1);
        line_idle(10);
        wait_done("hold42");
        f0 = n_frm + n_par + n_ovr;
        push_abort();
        fork
            send_frame(8'hE7, 8, 9, 0, 0, 1, 0, 1);
            begin repeat (40) @(posedge clk_i); #1 cfg_en_i = 1'b0; end
        join
        line_idle(10);
        wait_done("disable");
        check("disable_kept", {valid_o, data_o}, {1'b1, 8'h42});
        check("disable_quiet", n_frm + n_par + n_ovr - f0, 0);
        cfg_en_i = 1'b1;

        // Reset mid-frame clears everything.
        fork
            send_frame(8'h77, 8, 9, 0, 0, 1, 0, 1);
            begin repeat (50) @(posedge clk_i); #1 rstn_i = 1'b0; end
        join
        line_idle(3);
        #1 rstn_i = 1'b1;
        evq.delete();
        @(negedge clk_i);
        check("post_reset", {valid_o, busy_o, err_frame_o, err_parity_o, err_overrun_o, data_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulp_io_uart_rx.md
Name: pulp_io_uart_rx

Overview:
Serial-to-parallel UART receiver for the pulp-io peripheral subsystem. It samples the pad-side rx line, deframes start/data/optional parity/stop, and presents each byte on a valid/ready stream toward the uDMA RX channel. Runtime configuration comes from the peripheral register file, and error flags feed the peripheral event lines.

Parameters:
- DIV_W, 16, width of the baud divider; bit period = cfg_div_i+1 clk_i cycles
- SYNC_STAGES, 2, flops in the rx_i input synchronizer (min 2)

Ports:
- clk_i  in  1  peripheral clock
- rstn_i  in  1  asynchronous active-low reset
- rx_i  in  1  serial line from pad, idle high, asynchronous to clk_i
- cfg_en_i  in  1  receiver enable
- cfg_div_i  in  DIV_W  baud divider
- cfg_bits_i  in  2  data bits: 0=5, 1=6, 2=7, 3=8
- cfg_parity_en_i  in  1  expect parity bit
- cfg_parity_odd_i  in  1  1=odd parity, 0=even parity
- cfg_stop2_i  in  1  two stop bits
- data_o  out  8  received byte, LSB-aligned, upper bits zero
- valid_o  out  1  data_o holds an undelivered byte
- ready_i  in  1  consumer accepts data_o
- busy_o  out  1  FSM not in IDLE
- err_frame_o  out  1  one-cycle pulse: stop bit sampled low
- err_parity_o  out  1  one-cycle pulse: parity mismatch
- err_overrun_o  out  1  one-cycle pulse: frame completed while valid_o high

Behaviour:
- Reset: all outputs 0, FSM=IDLE, synchronizer flops preset to 1, counters 0.
- rx_i passes through SYNC_STAGES flops (rx_s); all sampling uses rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when cfg_en_i=1 and rx_s=0, go to START and load baud_cnt=0.
- START: count to cfg_div_i>>1 (mid-bit). If rx_s=1 there, treat as a glitch and return to IDLE. Otherwise reset baud_cnt and go to DATA.
- DATA, PARITY, STOP each sample when baud_cnt==cfg_div_i, then reset baud_cnt.
- DATA samples cfg_bits_i+5 bits, LSB first, into a shift register.
- After DATA, go to PARITY if cfg_parity_en_i=1, else to STOP.
- PARITY: expected bit = XOR(data bits) XOR cfg_parity_odd_i. A mismatch sets an internal flag.
- STOP: sample 1 or 2 stop bits (cfg_stop2_i). Any low stop bit sets the frame flag.
- At the last STOP sample, return to IDLE in the same cycle and resolve the frame:
  - frame error: err_frame_o pulses; byte dropped.
  - parity error (no frame error): err_parity_o pulses; byte dropped.
  - both: only err_frame_o pulses.
  - good byte with valid_o=0, or valid_o=1 and ready_i=1 in this cycle: data_o/valid_o load next cycle.
  - good byte with valid_o=1 and ready_i=0: err_overrun_o pulses; old data_o kept; new byte dropped.
- Output handshake: valid_o rises one cycle after the final stop sample. It clears on valid_o&&ready_i. data_o is stable while valid_o=1.
- cfg_div_i=0: one cycle per bit, mid-bit offset 0. This setting is legal.
- Config inputs are sampled live; software changes them only while busy_o=0.
- cfg_en_i deasserted mid-frame: FSM goes to IDLE next cycle and the partial frame is discarded without an error pulse. valid_o/data_o are unaffected.
- Line held low (break) is reported as a frame error. The FSM waits in IDLE for a new falling edge, i.e. rx_s must return to 1 before the next start.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: PULP_IO_UART_RX_PARITY_EN.
- Defined: parity behaves as described above.
- Undefined:
  - PARITY state, parity logic and the err_parity_o driver are not compiled.
  - cfg_parity_en_i and cfg_parity_odd_i are ignored.
  - err_parity_o is tied to 0.
  - DATA goes directly to STOP.
- The port list is identical in both builds.

Decomposition:
- pulp_io_pkg holds:
  - uart_rx_state_e enum (IDLE/START/DATA/PARITY/STOP)
  - uart_bits_e encoding for cfg_bits_i
  - localparam UART_MAX_BITS=8
- One natural sub-module: pulp_io_sync, a SYNC_STAGES-deep bit synchronizer with reset value parameter (1 here). It is reusable by other pad-input peripherals.

Test Plan:
- div=9, 8N1, send 0xA5 → valid_o rises 1 cycle after stop mid-sample with data_o=0xA5; no error pulses; busy_o falls the same cycle.
- 7 bits, even parity, send 0x35 with correct parity, then repeat with the parity bit flipped → first frame delivers data_o=0x35; second pulses err_parity_o once and valid_o stays 0.
- 8N1, stop bit driven 0 on byte 0x3C → err_frame_o pulses once, no valid_o; after the line returns high, 0x11 is received normally.
- Hold ready_i=0, send 0x01 then 0x02 → data_o=0x01 stays valid; err_overrun_o pulses once at the end of the second frame; ready_i=1 then clears valid_o.
- 3-cycle low glitch on rx_i with div=15 → FSM returns to IDLE from START; no valid_o and no errors.
- Deassert cfg_en_i during DATA, then rstn_i low mid-frame → FSM to IDLE with no pulses; after reset, all outputs read 0.
